// File: rtl/axis_tools_pkg.sv
// axis_tools_pkg: shared AXI-Stream payload helpers and arbiter state type
package axis_tools_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
  function automatic int axis_pld_width(int tdata, int tuser, int tid, int tkeep);
    return tdata + tuser + tid + tkeep + 1;
  endfunction
  function automatic int axis_max1(int w);
    return w > 0 ? w : 1;
  endfunction
endpackage

// File: rtl/axis_from_pld.sv
// axis_from_pld: unpacks a payload back into AXI-Stream fields, absent fields read 0
module axis_from_pld
  import axis_tools_pkg::*;
#(
  parameter int WIDTH_TDATA = 32,
  parameter int WIDTH_TUSER = 0,
  parameter int WIDTH_TID = 0,
  parameter int WIDTH_TKEEP = 4,
  localparam int PW = axis_pld_width(WIDTH_TDATA, WIDTH_TUSER, WIDTH_TID, WIDTH_TKEEP)
) (
  input  logic [PW-1:0]                     pld_i,
  output logic [WIDTH_TDATA-1:0]            tdata_o,
  output logic                              tlast_o,
  output logic [axis_max1(WIDTH_TUSER)-1:0] tuser_o,
  output logic [axis_max1(WIDTH_TID)-1:0]   tid_o,
  output logic [axis_max1(WIDTH_TKEEP)-1:0] tkeep_o
);
  localparam int OI = WIDTH_TKEEP;
  localparam int OU = WIDTH_TKEEP + WIDTH_TID;
  assign {tdata_o, tlast_o} = pld_i[PW-1 -: WIDTH_TDATA+1];
  if (WIDTH_TUSER > 0) begin : g_user
    assign tuser_o = pld_i[OU +: WIDTH_TUSER];
  end else begin : g_no_user
    assign tuser_o = '0;
  end
  if (WIDTH_TID > 0) begin : g_id
    assign tid_o = pld_i[OI +: WIDTH_TID];
  end else begin : g_no_id
    assign tid_o = '0;
  end
  if (WIDTH_TKEEP > 0) begin : g_keep
    assign tkeep_o = pld_i[0 +: WIDTH_TKEEP];
  end else begin : g_no_keep
    assign tkeep_o = '0;
  end
endmodule

// File: rtl/axis_rr_pick.sv
// axis_rr_pick: rotating-priority encoder, first request at or after ptr wins
module axis_rr_pick #(
  parameter int N = 4,
  localparam int SRC_W = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [SRC_W-1:0] ptr_i,
  output logic [SRC_W-1:0] gnt_idx_o,
  output logic             gnt_any_o
);
  logic [N-1:0] rot;
  logic [SRC_W-1:0] off;
  logic [SRC_W:0] sum;
  assign rot = N'({req_i, req_i} >> ptr_i);
  assign gnt_any_o = |req_i;
  // lowest set bit of the rotated request vector is the offset from ptr
  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) off = rot[k] ? SRC_W'(k) : off;
  end
  assign sum = {1'b0, ptr_i} + {1'b0, off};
  assign gnt_idx_o = sum >= (SRC_W+1)'(N) ? SRC_W'(sum - (SRC_W+1)'(N)) : sum[SRC_W-1:0];
endmodule

// File: rtl/axis_to_pld.sv
// axis_to_pld: packs one beat into {tdata, tlast, tuser, tid, tkeep}, absent fields omitted
module axis_to_pld
  import axis_tools_pkg::*;
#(
  parameter int WIDTH_TDATA = 32,
  parameter int WIDTH_TUSER = 0,
  parameter int WIDTH_TID = 0,
  parameter int WIDTH_TKEEP = 4,
  localparam int PW = axis_pld_width(WIDTH_TDATA, WIDTH_TUSER, WIDTH_TID, WIDTH_TKEEP)
) (
  input  logic [WIDTH_TDATA-1:0]            tdata_i,
  input  logic                              tlast_i,
  input  logic [axis_max1(WIDTH_TUSER)-1:0] tuser_i,
  input  logic [axis_max1(WIDTH_TID)-1:0]   tid_i,
  input  logic [axis_max1(WIDTH_TKEEP)-1:0] tkeep_i,
  output logic [PW-1:0]                     pld_o
);
  localparam int OI = WIDTH_TKEEP;
  localparam int OU = WIDTH_TKEEP + WIDTH_TID;
  assign pld_o[PW-1 -: WIDTH_TDATA+1] = {tdata_i, tlast_i};
  if (WIDTH_TUSER > 0) begin : g_user
    assign pld_o[OU +: WIDTH_TUSER] = tuser_i;
  end else begin : g_no_user
    logic unused_user;
    assign unused_user = ^tuser_i;
  end
  if (WIDTH_TID > 0) begin : g_id
    assign pld_o[OI +: WIDTH_TID] = tid_i;
  end else begin : g_no_id
    logic unused_id;
    assign unused_id = ^tid_i;
  end
  if (WIDTH_TKEEP > 0) begin : g_keep
    assign pld_o[0 +: WIDTH_TKEEP] = tkeep_i;
  end else begin : g_no_keep
    logic unused_keep;
    assign unused_keep = ^tkeep_i;
  end
endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-aware round-robin mux of N AXI-Stream sources onto one registered output
module axis_rr_arbiter
  import axis_tools_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int WIDTH_TDATA = 32,
  parameter int WIDTH_TUSER = 0,
  parameter int WIDTH_TID = 0,
  parameter int WIDTH_TKEEP = 4,
  localparam int SRC_W = N_INPUTS > 1 ? $clog2(N_INPUTS) : 1,
  localparam int UW = axis_max1(WIDTH_TUSER),
  localparam int IW = axis_max1(WIDTH_TID),
  localparam int KW = axis_max1(WIDTH_TKEEP)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_INPUTS-1:0]             axis_in_tvalid,
  output logic [N_INPUTS-1:0]             axis_in_tready,
  input  logic [N_INPUTS*WIDTH_TDATA-1:0] axis_in_tdata,
  input  logic [N_INPUTS-1:0]             axis_in_tlast,
  input  logic [N_INPUTS*UW-1:0]          axis_in_tuser,
  input  logic [N_INPUTS*IW-1:0]          axis_in_tid,
  input  logic [N_INPUTS*KW-1:0]          axis_in_tkeep,
  output logic                            axis_out_tvalid,
  input  logic                            axis_out_tready,
  output logic [WIDTH_TDATA-1:0]          axis_out_tdata,
  output logic                            axis_out_tlast,
  output logic [UW-1:0]                   axis_out_tuser,
  output logic [IW-1:0]                   axis_out_tid,
  output logic [KW-1:0]                   axis_out_tkeep,
  output logic [SRC_W-1:0]                axis_out_tsrc
);
  localparam int PW = axis_pld_width(WIDTH_TDATA, WIDTH_TUSER, WIDTH_TID, WIDTH_TKEEP);
  arb_state_e state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d, ptr_q, ptr_d, tsrc_q, tsrc_d, gnt_idx, next_ptr;
  logic out_valid_q, out_valid_d, gnt_any, sel_valid, sel_last, can_load, locked, xfer;
  logic [PW-1:0] out_pld_q, out_pld_d, sel_pld;
  logic [PW-1:0] pld_w [N_INPUTS];
  for (genvar g = 0; g < N_INPUTS; g++) begin : g_src
    axis_to_pld #(
      .WIDTH_TDATA(WIDTH_TDATA), .WIDTH_TUSER(WIDTH_TUSER),
      .WIDTH_TID(WIDTH_TID), .WIDTH_TKEEP(WIDTH_TKEEP)
    ) u_pack (
      .tdata_i(axis_in_tdata[g*WIDTH_TDATA +: WIDTH_TDATA]),
      .tlast_i(axis_in_tlast[g]),
      .tuser_i(axis_in_tuser[g*UW +: UW]),
      .tid_i  (axis_in_tid[g*IW +: IW]),
      .tkeep_i(axis_in_tkeep[g*KW +: KW]),
      .pld_o  (pld_w[g])
    );
    assign axis_in_tready[g] = locked && grant_q == SRC_W'(g) && can_load;
  end
  axis_rr_pick #(.N(N_INPUTS)) u_pick (
    .req_i    (axis_in_tvalid),
    .ptr_i    (ptr_q),
    .gnt_idx_o(gnt_idx),
    .gnt_any_o(gnt_any)
  );
  // route the granted source's beat to the output register input
  always_comb begin
    sel_pld = '0;
    sel_valid = 1'b0;
    sel_last = 1'b0;
    for (int k = 0; k < N_INPUTS; k++) begin
      sel_pld = grant_q == SRC_W'(k) ? pld_w[k] : sel_pld;
      sel_valid = grant_q == SRC_W'(k) ? axis_in_tvalid[k] : sel_valid;
      sel_last = grant_q == SRC_W'(k) ? axis_in_tlast[k] : sel_last;
    end
  end
  assign locked = state_q == ARB_LOCKED;
  assign can_load = !out_valid_q || axis_out_tready;
  assign xfer = locked && sel_valid && can_load;
  assign next_ptr = grant_q == SRC_W'(N_INPUTS - 1) ? '0 : grant_q + SRC_W'(1);
  // arbitration FSM and output register next state; tlast releases the lock on its accept edge
  always_comb begin
    state_d = (!locked && gnt_any) ? ARB_LOCKED : (xfer && sel_last) ? ARB_IDLE : state_q;
    grant_d = (!locked && gnt_any) ? gnt_idx : grant_q;
    ptr_d = (xfer && sel_last) ? next_ptr : ptr_q;
    out_valid_d = xfer || (out_valid_q && !axis_out_tready);
    out_pld_d = xfer ? sel_pld : out_pld_q;
    tsrc_d = xfer ? grant_q : tsrc_q;
  end
  // state and output register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q <= '0;
      out_valid_q <= 1'b0;
      out_pld_q <= '0;
      tsrc_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      out_valid_q <= out_valid_d;
      out_pld_q <= out_pld_d;
      tsrc_q <= tsrc_d;
    end
  end
  axis_from_pld #(
    .WIDTH_TDATA(WIDTH_TDATA), .WIDTH_TUSER(WIDTH_TUSER),
    .WIDTH_TID(WIDTH_TID), .WIDTH_TKEEP(WIDTH_TKEEP)
  ) u_unpack (
    .pld_i  (out_pld_q),
    .tdata_o(axis_out_tdata),
    .tlast_o(axis_out_tlast),
    .tuser_o(axis_out_tuser),
    .tid_o  (axis_out_tid),
    .tkeep_o(axis_out_tkeep)
  );
  assign axis_out_tvalid = out_valid_q;
  assign axis_out_tsrc = tsrc_q;
endmodule
